mem_access_ctrl: RTL
====================

# mem_access_ctrl

MEM-stage sequencer sitting between the EX/MEM pipeline latch outputs and a handshaked data memory. It turns each load/store held in the latch into exactly one request/acknowledge transaction. It stalls the whole pipeline, including the EX/MEM latch, until the access completes. It also aligns read data into ReadDataM and flags misaligned or timed-out accesses.

## Interface
- TIMEOUT, 15: maximum cycles in REQ without mem_ack before abort; 1..255.
- clk  in  1  pipeline clock; all state updates on rising edge.
- inicio  in  1  reset; asynchronous, active-high.
- MemReadM  in  2  read size from latch: 00 none, 01 byte, 10 half, 11 word.
- MemWriteM  in  4  store byte enables from latch; 0000 means no store.
- ALUOutM  in  32  effective address.
- WriteDataM  in  32  store data, already lane-positioned.
- mem_req  out  1  request to memory, registered.
- mem_we  out  1  1 = write, registered.
- mem_be  out  4  byte enables for the transaction, registered.
- mem_addr  out  32  word address {ALUOutM[31:2],2'b00}, registered.
- mem_wdata  out  32  store data, registered.
- mem_ack  in  1  memory completion; sampled only in REQ.
- mem_rdata  in  32  read data, valid with mem_ack.
- stall  out  1  freeze all pipeline latches; combinational.
- ReadDataM  out  32  aligned load result, registered.
- mem_err  out  1  sticky error flag, cleared only by inicio.

## Operation
- Access present: acc = (MemReadM != 0) | (MemWriteM != 0).
- FSM states: IDLE, REQ, DONE.
- IDLE, acc=0: stay in IDLE.
- IDLE, acc=1 and legal: go to REQ and load mem_req=1, mem_we, mem_be, mem_addr, mem_wdata.
- IDLE, acc=1 and illegal: go to DONE, set mem_err, ReadDataM<=0, no request.
- REQ, mem_ack=1: go to DONE, mem_req<=0, capture read data when mem_we=0.
- REQ, timeout: go to DONE, mem_req<=0, set mem_err, ReadDataM<=0.
- DONE: go to IDLE unconditionally.
- stall = ~inicio & ((IDLE & acc) | REQ). stall is 0 in DONE, so the latch advances exactly once and the access is never served twice.
- Read lane enables:
  - byte: one-hot by addr[1:0].
  - half: 0011 if addr[1]=0, else 1100.
  - word: 1111.
- Write enables: MemWriteM passed through unchanged.
- Illegal access is any of:
  - half read with addr[0]=1;
  - word read with addr[1:0]!=0;
  - MemWriteM not in {0001,0010,0100,1000,0011,1100,1111};
  - MemReadM!=0 together with MemWriteM!=0.
- ReadDataM on a read: mem_rdata >> (8*addr[1:0]), with bits above the access size zeroed. Sign extension happens downstream. Unchanged on writes.
- Timeout counter: 8 bits, cleared on entering REQ, incremented every REQ cycle without ack. Abort fires when count == TIMEOUT-1 with no ack.

## Timing
- Reset values:
  - state IDLE; mem_req, mem_we, mem_err = 0.
  - mem_be = 0; mem_addr, mem_wdata, ReadDataM = 0.
  - stall = 0 while inicio is high.
- Minimum service: 3 cycles (IDLE-stall, REQ with ack, DONE). Stall lasts 2 cycles.
- Each extra wait cycle before mem_ack adds one stall cycle.
- Handshake: mem_req rises on the edge leaving IDLE and stays high, with address/data/enables stable, until the edge after mem_ack is sampled high. mem_ack outside REQ is ignored.
- Back-to-back accesses: the next access is seen in IDLE the cycle after DONE, so there is no bubble beyond the fixed 3-cycle service.
- Timeout: with no ack, mem_req is high exactly TIMEOUT cycles, then DONE.
- ack arriving on the timeout cycle: ack wins and mem_err is not set.
- inicio mid-transaction: mem_req drops asynchronously, state returns to IDLE, the access is abandoned and mem_err is cleared.

## Configuration
- MEM_TIMEOUT_EN defined: timeout counter and abort path are built as described.
- MEM_TIMEOUT_EN undefined:
  - no counter; REQ waits indefinitely for mem_ack;
  - mem_err is set only by illegal accesses;
  - TIMEOUT parameter is ignored.

## Test plan
- Word load, addr 0x100, ack on the first REQ cycle, rdata 0xDEADBEEF -> mem_be=1111, mem_addr=0x100, stall high 2 cycles, ReadDataM=0xDEADBEEF, mem_err=0.
- Byte load, addr 0x103, rdata 0xAABBCCDD, ack after 3 wait cycles -> mem_be=1000, stall high 5 cycles, ReadDataM=0x000000AA.
- Store, MemWriteM=1100, addr 0x204, data 0x12340000 -> mem_we=1, mem_be=1100, mem_wdata=0x12340000, exactly one mem_req pulse train, ReadDataM unchanged.
- Half load at addr 0x101 -> no mem_req, stall 1 cycle, mem_err=1 and sticky across following legal accesses until inicio.
- With MEM_TIMEOUT_EN and TIMEOUT=15, no ack -> mem_req high 15 cycles, then mem_err=1 and ReadDataM=0. Without the macro -> stall holds indefinitely.
- inicio pulsed while in REQ -> mem_req, stall and mem_err 0 immediately. After release, the same latched access is re-served from IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one request/ack transaction per EX/MEM load or store, with pipeline stall,
// read-lane alignment and a sticky error flag. Define MEM_TIMEOUT_EN to build the REQ-state abort.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        inicio,
  input  logic [1:0]  MemReadM,
  input  logic [3:0]  MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ReadDataM,
  output logic        mem_err
);

  if ((TIMEOUT == 0) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic        acc, rd_legal, wr_legal, legal;
  logic [3:0]  rd_be;
  logic [31:0] shifted, aligned;

  assign acc = (MemReadM != 2'b00) | (MemWriteM != 4'b0000);

  always_comb begin
    rd_be    = 4'b0000;
    rd_legal = 1'b1;
    unique case (MemReadM)
      2'b01: rd_be = 4'b0001 << ALUOutM[1:0];
      2'b10: begin
        rd_be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        rd_legal = ~ALUOutM[0];
      end
      2'b11: begin
        rd_be    = 4'b1111;
        rd_legal = (ALUOutM[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (MemWriteM)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: wr_legal = 1'b1;
      default:                   wr_legal = 1'b0;
    endcase
  end

  // A combined load+store in one latch slot has no defined meaning.
  assign legal = rd_legal & wr_legal & ~((MemReadM != 2'b00) & (MemWriteM != 4'b0000));

  // Latch contents are frozen by stall, but offset/size are kept locally anyway.
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (size_q)
      2'b01:   aligned = {24'h0, shifted[7:0]};
      2'b10:   aligned = {16'h0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    off_d   = off_q;
    size_d  = size_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          if (legal) begin
            state_d = StReq;
            req_d   = 1'b1;
            we_d    = (MemWriteM != 4'b0000);
            be_d    = (MemWriteM != 4'b0000) ? MemWriteM : rd_be;
            addr_d  = {ALUOutM[31:2], 2'b00};
            wdata_d = WriteDataM;
            off_d   = ALUOutM[1:0];
            size_d  = MemReadM;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) rdata_d = aligned;
        end
`ifdef MEM_TIMEOUT_EN
        // Ack on the last allowed cycle takes priority over the abort.
        else if (cnt_q == TimeoutLast) begin
          state_d = StDone;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      off_q   <= off_d;
      size_q  <= size_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // DONE drops stall so the latch advances exactly once per access.
  assign stall = ~inicio & (((state_q == StIdle) & acc) | (state_q == StReq));

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign mem_err   = err_q;

endmodule
